tape_csw_player: RTL and testbench
==================================

Name: tape_csw_player

Overview:
Plays a CSW v1 (RLE pulse-length) tape image and drives the motherboard `tape_in` input. It sits directly upstream of the motherboard's PPI port B bit 7.
- Byte stream arrives from the SDRAM/file loader through a request/valid handshake.
- Playback is paced by a fractional sample-rate accumulator.
- Playback is gated by the motherboard's `tape_motor` output, so the CPC firmware loads the image exactly as from a cassette.

Parameters:
CLK_HZ, 64000000, frequency of clk in Hz; accumulator modulus.
ACC_W, 27, accumulator width; must satisfy 2^ACC_W > 2*CLK_HZ.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
play  in  1  level; 1 = image mounted and playing; 0 = stop.
motor  in  1  tape motor relay (motherboard tape_motor); 0 pauses playback.
rate  in  20  CSW sample rate in Hz (from header); 0 = no sample ticks.
init_level  in  1  polarity of the first pulse (CSW header flag).
data_in  in  8  next image byte.
data_valid  in  1  data_in valid; consumed when data_req=1 in the same cycle.
eof  in  1  source has no more bytes.
data_req  out  1  block wants a byte.
tape_in  out  1  tape level to motherboard.
active  out  1  1 while not in IDLE or DONE.
underrun  out  1  sticky; a sample tick was lost while waiting for data.

Behaviour:
Reset values: tape_in=0, data_req=0, active=0, underrun=0, accumulator=0, state=IDLE. Reset has priority over every other input in every state.

Sample tick (tick):
- Each clk with motor=1: acc <= acc+rate.
- If acc+rate >= CLK_HZ: acc <= acc+rate-CLK_HZ and tick=1 that cycle.
- With motor=0, acc holds and tick=0.
- acc is cleared on the IDLE->FETCH transition.

States:
- IDLE: data_req=0. When play=1: tape_in<=init_level, underrun<=0, go FETCH.
- FETCH: data_req=1.
  - On valid byte b≠0: cnt<=b, go RUN.
  - On b=0: go EXT0.
  - If eof=1 and no valid byte in the same cycle: go DONE (valid wins over eof).
- EXT0..EXT3: data_req=1. Each valid byte loads cnt[7:0], [15:8], [23:16], [31:24] (little-endian), advancing one state per byte.
  - EXT3 goes to RUN.
  - If the 32-bit length is 0, cnt<=1.
  - eof without valid: go DONE.
- RUN: data_req=0.
  - On tick with cnt>1: cnt<=cnt-1.
  - On tick with cnt==1: tape_in<=~tape_in, go FETCH.
  - Pulse duration is exactly cnt ticks; the toggle lands on the cycle after the last tick.
- DONE: data_req=0, active=0, tape_in holds. Left only via play=0 (to IDLE) or reset.

Underrun:
- A tick occurring in FETCH or EXTn sets underrun=1 (sticky until reset or the next IDLE->FETCH).
- The tick itself is dropped: the pulse stretches, no compensation.

Handshake:
- data_req stays high until the byte is accepted.
- The source may hold data_valid high across cycles. At most one byte is consumed per cycle.
- Exactly one byte is consumed per accept.

Simultaneous events and state changes:
- play=0 in any non-IDLE state: go IDLE next cycle, data_req<=0, tape_in holds its level.
- A byte presented in that same cycle is not consumed.
- motor 1->0 mid-pulse freezes cnt and acc. tape_in is unchanged. Fetch states still accept bytes.
- motor 0->1 resumes from the frozen values.
- cnt is 32 bits; no wrap occurs since cnt>=1 whenever RUN is entered.

Test Plan:
1. CLK_HZ=1000, rate=250 (tick every 4 clk), init_level=0, bytes 03,02, zero-latency source -> tape_in=0 for 12 clk, then 1 for 8 clk, then 0 while FETCH waits for the next byte; active=1 throughout.
2. Same rate, bytes 00,10,00,00,00 -> one pulse of exactly 16 ticks (64 clk) after the fifth byte is accepted; bytes 00,00,00,00,00 -> pulse of 1 tick.
3. Pulse of 05; motor=0 for 100 clk starting 2 ticks into the pulse -> pulse lasts 20+100 clk, tape_in does not change during the pause, acc resumes without an extra tick.
4. Source raises eof with data_valid=0 while in FETCH after two pulses -> DONE next cycle, data_req=0, active=0, tape_in holds last level. Then play=0 -> IDLE; play=1 -> tape_in=init_level, underrun=0.
5. Source delays data_valid 20 clk after data_req with tick every 4 clk -> underrun=1 and stays 1 through subsequent well-fed pulses until play is toggled.
6. Assert reset for one cycle mid-RUN and mid-EXT2 with data_valid=1 -> next cycle tape_in=0, data_req=0, active=0, underrun=0, no byte consumed.

Source files
------------

// File: rtl/tape_csw_if.sv
// Byte-stream handshake between the SDRAM/file loader and the CSW player.
interface tape_csw_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       eof;
  logic       data_req;

  // Loader side: presents bytes, watches the request
  modport master (
    output data_in,
    output data_valid,
    output eof,
    input  data_req
  );

  // Player side: requests and consumes bytes
  modport slave (
    input  data_in,
    input  data_valid,
    input  eof,
    output data_req
  );
endinterface

// File: rtl/tape_csw_player.sv
// CSW v1 (RLE pulse-length) tape player driving the motherboard tape_in line.
// A fractional accumulator turns clk into sample ticks at the image's rate;
// each pulse length (in ticks) is read from the byte stream, and tape_in
// toggles once the pulse has elapsed. The motor relay gates the tick source.
module tape_csw_player #(
  parameter int unsigned CLK_HZ = 64000000,
  parameter int unsigned ACC_W  = 27
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        play,
  input  logic        motor,
  input  logic [19:0] rate,
  input  logic        init_level,
  tape_csw_if.slave   src,
  output logic        tape_in,
  output logic        active,
  output logic        underrun
);

  localparam logic [ACC_W-1:0] MOD = ACC_W'(CLK_HZ);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXT0, S_EXT1, S_EXT2, S_EXT3, S_RUN, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
  logic [31:0]      cnt_q, cnt_d, ext_len;
  logic             tape_d, und_d, req_d, act_d;
  logic             tick_c, accept_c, fetch_c;

  // Next-state, pulse counter, accumulator and output-level logic
  always_comb begin
    acc_sum  = acc_q + ACC_W'(rate);
    tick_c   = motor && (acc_sum >= MOD);
    accept_c = src.data_req && src.data_valid;
    fetch_c  = state_q inside {S_FETCH, S_EXT0, S_EXT1, S_EXT2, S_EXT3};
    ext_len  = {src.data_in, cnt_q[23:0]};
    state_d  = state_q;
    cnt_d    = cnt_q;
    tape_d   = tape_in;
    und_d    = underrun;
    acc_d    = acc_q;
    if (motor) acc_d = tick_c ? (acc_sum - MOD) : acc_sum;

    if (state_q != S_IDLE && !play) begin
      // Stop: drop back to IDLE holding the line level, byte not taken
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (play) begin
            tape_d  = init_level;
            und_d   = 1'b0;
            acc_d   = '0;
            state_d = S_FETCH;
          end
        end
        S_FETCH: begin
          if (accept_c) begin
            if (src.data_in != 8'd0) begin
              cnt_d   = {24'd0, src.data_in};
              state_d = S_RUN;
            end else begin
              state_d = S_EXT0;
            end
          end else if (src.eof) begin
            state_d = S_DONE;
          end
        end
        S_EXT0, S_EXT1, S_EXT2: begin
          if (accept_c) begin
            case (state_q)
              S_EXT0:  begin cnt_d[7:0]   = src.data_in; state_d = S_EXT1; end
              S_EXT1:  begin cnt_d[15:8]  = src.data_in; state_d = S_EXT2; end
              default: begin cnt_d[23:16] = src.data_in; state_d = S_EXT3; end
            endcase
          end else if (src.eof) begin
            state_d = S_DONE;
          end
        end
        S_EXT3: begin
          if (accept_c) begin
            // A zero extended length still plays as one tick
            cnt_d   = (ext_len == 32'd0) ? 32'd1 : ext_len;
            state_d = S_RUN;
          end else if (src.eof) begin
            state_d = S_DONE;
          end
        end
        S_RUN: begin
          if (tick_c) begin
            if (cnt_q > 32'd1) begin
              cnt_d = cnt_q - 32'd1;
            end else begin
              tape_d  = ~tape_in;
              state_d = S_FETCH;
            end
          end
        end
        default: ;
      endcase
      // A tick while still waiting for length bytes is lost
      if (fetch_c && tick_c) und_d = 1'b1;
    end

    req_d = state_d inside {S_FETCH, S_EXT0, S_EXT1, S_EXT2, S_EXT3};
    act_d = !(state_d inside {S_IDLE, S_DONE});
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      tape_in      <= 1'b0;
      underrun     <= 1'b0;
      src.data_req <= 1'b0;
      active       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      tape_in      <= tape_d;
      underrun     <= und_d;
      src.data_req <= req_d;
      active       <= act_d;
    end
  end

endmodule

// File: tb/tb_tape_csw_player.sv
// Self-checking bench for tape_csw_player. Expected waveforms come from a
// pulse-level model: tick times from plain rate arithmetic over motor-on
// cycles, then pulses laid end to end with fetch cycles in between.
module tb_tape_csw_player;
  localparam int unsigned CLK_HZ = 1000;
  localparam int unsigned ACC_W  = 27;
  localparam int          MAXC   = 4096;

  logic        clk = 1'b0;
  logic        reset, play, motor, init_level;
  logic [19:0] rate;
  logic        tape_in, active, underrun;

  tape_csw_if src_if ();

  tape_csw_player #(.CLK_HZ(CLK_HZ), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset), .play(play), .motor(motor), .rate(rate),
    .init_level(init_level), .src(src_if), .tape_in(tape_in),
    .active(active), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] src_q[$];
  logic exp_tape[MAXC];
  logic exp_req[MAXC];
  logic exp_und[MAXC];
  logic mot[MAXC];
  logic tk[MAXC];
  logic model_level, model_und;

  // Expected per-cycle waveforms for the bytes currently in src_q
  task automatic build_model(input int rate_v, input logic lvl, input int ncyc,
                             input int pause_at, input int pause_len);
    int lens[$];
    int nbs[$];
    int i, k, p, rem;
    longint m, v;
    logic lv, und;
    i = 0;
    while (i < src_q.size()) begin
      if (src_q[i] != 8'd0) begin
        lens.push_back(int'(src_q[i])); nbs.push_back(1); i++;
      end else begin
        v = 0;
        for (int b = 0; b < 4; b++) v += longint'(src_q[i+1+b]) << (8*b);
        if (v == 0) v = 1;
        lens.push_back(int'(v)); nbs.push_back(5); i += 5;
      end
    end
    m = 0;
    for (int c = 0; c < ncyc; c++) begin
      mot[c] = !(c >= pause_at && c < pause_at + pause_len);
      tk[c]  = 1'b0;
      if (mot[c]) begin
        tk[c] = (((m+1)*longint'(rate_v))/longint'(CLK_HZ)) > ((m*longint'(rate_v))/longint'(CLK_HZ));
        m++;
      end
    end
    k = 0; p = 0; lv = lvl; und = 1'b0;
    while (k < ncyc) begin
      if (p < lens.size()) begin
        for (int j = 0; j < nbs[p] && k < ncyc; j++) begin
          exp_req[k] = 1'b1; exp_tape[k] = lv; exp_und[k] = und;
          if (tk[k]) und = 1'b1;
          k++;
        end
        rem = lens[p];
        while (k < ncyc && rem > 0) begin
          exp_req[k] = 1'b0; exp_tape[k] = lv; exp_und[k] = und;
          if (tk[k]) rem--;
          k++;
        end
        if (rem == 0) lv = ~lv;
        p++;
      end else begin
        exp_req[k] = 1'b1; exp_tape[k] = lv; exp_und[k] = und;
        if (tk[k]) und = 1'b1;
        k++;
      end
    end
    model_level = lv;
    model_und   = und;
  endtask

  // Start playback from IDLE with a zero-latency source and compare every cycle
  task automatic run_stream(input int rate_v, input logic lvl, input int ncyc,
                            input int pause_at, input int pause_len, input string name);
    logic acc;
    build_model(rate_v, lvl, ncyc, pause_at, pause_len);
    @(negedge clk);
    rate = 20'(rate_v); init_level = lvl; motor = 1'b1; play = 1'b1;
    src_if.data_valid = 1'b0;
    @(posedge clk);
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      n_checks += 4;
      if (tape_in !== exp_tape[k]) begin
        n_fail++; $display("FAIL %s tape_in cyc %0d: got %b want %b", name, k, tape_in, exp_tape[k]);
      end
      if (src_if.data_req !== exp_req[k]) begin
        n_fail++; $display("FAIL %s data_req cyc %0d: got %b want %b", name, k, src_if.data_req, exp_req[k]);
      end
      if (underrun !== exp_und[k]) begin
        n_fail++; $display("FAIL %s underrun cyc %0d: got %b want %b", name, k, underrun, exp_und[k]);
      end
      if (active !== 1'b1) begin
        n_fail++; $display("FAIL %s active cyc %0d: got %b want 1", name, k, active);
      end
      motor = mot[k];
      if (src_q.size() > 0) begin
        src_if.data_valid = 1'b1; src_if.data_in = src_q[0];
      end else begin
        src_if.data_valid = 1'b0;
      end
      acc = src_if.data_req && src_if.data_valid;
      @(posedge clk);
      if (acc) void'(src_q.pop_front());
    end
  endtask

  task automatic stop_play();
    @(negedge clk);
    play = 1'b0; src_if.data_valid = 1'b0; src_if.eof = 1'b0; motor = 1'b1;
    @(posedge clk);
    src_q.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; play = 1'b0; motor = 1'b1; rate = 20'd250; init_level = 1'b0;
    src_if.data_valid = 1'b0; src_if.data_in = 8'd0; src_if.eof = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_checks += 4;
    if (tape_in !== 1'b0)        begin n_fail++; $display("FAIL reset tape_in: got %b want 0", tape_in); end
    if (src_if.data_req !== 1'b0) begin n_fail++; $display("FAIL reset data_req: got %b want 0", src_if.data_req); end
    if (active !== 1'b0)         begin n_fail++; $display("FAIL reset active: got %b want 0", active); end
    if (underrun !== 1'b0)       begin n_fail++; $display("FAIL reset underrun: got %b want 0", underrun); end
    @(posedge clk);
  endtask

  task automatic test_basic();
    src_q = '{8'h03, 8'h02};
    run_stream(250, 1'b0, 40, 0, 0, "basic");
    stop_play();
  endtask

  task automatic test_ext();
    src_q = '{8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_stream(250, 1'b1, 100, 0, 0, "ext");
    stop_play();
  endtask

  task automatic test_motor();
    src_q = '{8'h05};
    run_stream(250, 1'b0, 140, 8, 100, "motor");
    stop_play();
  endtask

  task automatic test_eof();
    src_q = '{8'h04, 8'h02};
    run_stream(250, 1'b1, 40, 0, 0, "eof_pre");
    @(negedge clk);
    src_if.eof = 1'b1; src_if.data_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    src_if.eof = 1'b0;
    n_checks += 4;
    if (src_if.data_req !== 1'b0) begin n_fail++; $display("FAIL eof data_req: got %b want 0", src_if.data_req); end
    if (active !== 1'b0)          begin n_fail++; $display("FAIL eof active: got %b want 0", active); end
    if (tape_in !== model_level)  begin n_fail++; $display("FAIL eof tape_in: got %b want %b", tape_in, model_level); end
    if (underrun !== model_und)   begin n_fail++; $display("FAIL eof underrun: got %b want %b", underrun, model_und); end
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_checks += 2;
    if (active !== 1'b0)         begin n_fail++; $display("FAIL done_hold active: got %b want 0", active); end
    if (tape_in !== model_level) begin n_fail++; $display("FAIL done_hold tape_in: got %b want %b", tape_in, model_level); end
    play = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks += 2;
    if (active !== 1'b0)          begin n_fail++; $display("FAIL idle active: got %b want 0", active); end
    if (src_if.data_req !== 1'b0) begin n_fail++; $display("FAIL idle data_req: got %b want 0", src_if.data_req); end
    init_level = 1'b0; play = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks += 3;
    if (tape_in !== 1'b0)         begin n_fail++; $display("FAIL replay tape_in: got %b want 0", tape_in); end
    if (underrun !== 1'b0)        begin n_fail++; $display("FAIL replay underrun: got %b want 0", underrun); end
    if (src_if.data_req !== 1'b1) begin n_fail++; $display("FAIL replay data_req: got %b want 1", src_if.data_req); end
    stop_play();
  endtask

  task automatic test_underrun();
    logic acc, prev;
    int toggles;
    src_q.delete();
    @(negedge clk);
    rate = 20'd250; init_level = 1'b0; motor = 1'b1; play = 1'b1; src_if.data_valid = 1'b0;
    @(posedge clk);
    repeat (20) begin @(negedge clk); @(posedge clk); end
    src_q = '{8'h02, 8'h03};
    toggles = 0; prev = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      n_checks++;
      if (underrun !== 1'b1) begin n_fail++; $display("FAIL underrun_sticky cyc %0d: got %b want 1", k, underrun); end
      if (tape_in !== prev) toggles++;
      prev = tape_in;
      if (src_q.size() > 0) begin
        src_if.data_valid = 1'b1; src_if.data_in = src_q[0];
      end else begin
        src_if.data_valid = 1'b0;
      end
      acc = src_if.data_req && src_if.data_valid;
      @(posedge clk);
      if (acc) void'(src_q.pop_front());
    end
    n_checks++;
    if (toggles != 2) begin n_fail++; $display("FAIL underrun_pulses toggles: got %0d want 2", toggles); end
    stop_play();
    @(negedge clk);
    play = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (underrun !== 1'b0) begin n_fail++; $display("FAIL underrun_clear: got %b want 0", underrun); end
    stop_play();
  endtask

  task automatic test_reset_mid();
    logic acc;
    src_q = '{8'h40};
    run_stream(250, 1'b1, 20, 0, 0, "pre_reset_run");
    @(negedge clk);
    reset = 1'b1; src_if.data_valid = 1'b1; src_if.data_in = 8'h55;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; src_if.data_valid = 1'b0;
    n_checks += 4;
    if (tape_in !== 1'b0)         begin n_fail++; $display("FAIL rst_run tape_in: got %b want 0", tape_in); end
    if (src_if.data_req !== 1'b0) begin n_fail++; $display("FAIL rst_run data_req: got %b want 0", src_if.data_req); end
    if (active !== 1'b0)          begin n_fail++; $display("FAIL rst_run active: got %b want 0", active); end
    if (underrun !== 1'b0)        begin n_fail++; $display("FAIL rst_run underrun: got %b want 0", underrun); end
    stop_play();
    src_q = '{8'h00, 8'h05, 8'h00};
    @(negedge clk);
    init_level = 1'b1; play = 1'b1; src_if.data_valid = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      src_if.data_valid = 1'b1; src_if.data_in = src_q[0];
      acc = src_if.data_req && src_if.data_valid;
      @(posedge clk);
      if (acc) void'(src_q.pop_front());
    end
    @(negedge clk);
    n_checks += 2;
    if (src_if.data_req !== 1'b1) begin n_fail++; $display("FAIL ext2 data_req: got %b want 1", src_if.data_req); end
    if (tape_in !== 1'b1)         begin n_fail++; $display("FAIL ext2 tape_in: got %b want 1", tape_in); end
    reset = 1'b1; src_if.data_valid = 1'b1; src_if.data_in = 8'h33;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; play = 1'b0; src_if.data_valid = 1'b0;
    n_checks += 4;
    if (tape_in !== 1'b0)         begin n_fail++; $display("FAIL rst_ext2 tape_in: got %b want 0", tape_in); end
    if (src_if.data_req !== 1'b0) begin n_fail++; $display("FAIL rst_ext2 data_req: got %b want 0", src_if.data_req); end
    if (active !== 1'b0)          begin n_fail++; $display("FAIL rst_ext2 active: got %b want 0", active); end
    if (underrun !== 1'b0)        begin n_fail++; $display("FAIL rst_ext2 underrun: got %b want 0", underrun); end
    stop_play();
  endtask

  task automatic test_random();
    int rate_v, np, pa, pl;
    logic lvl;
    for (int it = 0; it < 4; it++) begin
      src_q.delete();
      rate_v = int'($urandom_range(50, 1000));
      lvl    = 1'($urandom_range(0, 1));
      np     = int'($urandom_range(1, 5));
      for (int p = 0; p < np; p++) begin
        if ($urandom_range(0, 3) != 0) begin
          src_q.push_back(8'($urandom_range(1, 12)));
        end else begin
          src_q.push_back(8'd0);
          src_q.push_back(8'($urandom_range(0, 20)));
          src_q.push_back(8'd0); src_q.push_back(8'd0); src_q.push_back(8'd0);
        end
      end
      pa = int'($urandom_range(0, 300));
      pl = int'($urandom_range(0, 60));
      run_stream(rate_v, lvl, 2500, pa, pl, "random");
      stop_play();
    end
  endtask

  initial begin
    reset = 1'b1; play = 1'b0; motor = 1'b1; rate = 20'd0; init_level = 1'b0;
    src_if.data_valid = 1'b0; src_if.data_in = 8'd0; src_if.eof = 1'b0;
    test_reset();
    test_basic();
    test_ext();
    test_motor();
    test_eof();
    test_underrun();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
